dat_read_buffer: RTL
====================

# dat_read_buffer

Receive-side block buffer for the SDHCI data path. It sits directly downstream of the DAT-line deserializer and captures its 32-bit words into a one-block buffer. It checks each finished block for CRC, end-bit and length errors, then exposes the block to the register interface as a show-ahead read port. For multi-block reads it sequences the deserializer, starting the next block only after the current one has been fully drained.

## Interface
- MaxBlockBitSize, default 12: width of the block size in bytes; the buffer holds 2**(MaxBlockBitSize-2) words.
- BlockCountWidth, default 16: width of the block counter.

- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a read transfer; latches block_size_i and block_count_i.
- block_size_i  in  MaxBlockBitSize  block size in bytes, 1..2**MaxBlockBitSize-1.
- block_count_i  in  BlockCountWidth  number of blocks in the transfer.
- abort_i  in  1  cancel the transfer immediately.
- dat_start_o  out  1  one-cycle pulse that starts the deserializer for one block.
- wr_valid_i  in  1  deserialized word valid.
- wr_data_i  in  32  deserialized word, byte 0 in bits [7:0].
- blk_done_i  in  1  block finished; may coincide with wr_valid_i.
- crc_err_i  in  1  CRC error; sampled only with blk_done_i.
- end_bit_err_i  in  1  end-bit error; sampled only with blk_done_i.
- rd_en_i  in  1  consume the current buffer word.
- rd_data_o  out  32  current buffer word; 0 outside DRAIN.
- buffer_read_ready_o  out  1  pulse: a block is ready to drain.
- transfer_complete_o  out  1  pulse: the last block has been drained.
- data_crc_err_o  out  1  pulse: the block failed its CRC check.
- data_end_bit_err_o  out  1  pulse: the block failed its end-bit check.
- length_err_o  out  1  pulse: received word count ≠ expected.
- busy_o  out  1  high whenever state ≠ IDLE.

## Operation
- Expected words per block: words = (block_size + 3) >> 2, computed at MaxBlockBitSize-1 bits. A partial final word is zero-padded by the upstream stage.
- Pointers wr_ptr and rd_ptr are MaxBlockBitSize-1 bits wide. blocks_left is BlockCountWidth bits wide.
- The FSM has four states: IDLE, ARM, FILL and DRAIN.
- **IDLE:**
  - start_i with block_count_i = 0: transfer_complete_o pulses; the FSM stays in IDLE.
  - start_i with block_count_i > 0: latch words, set blocks_left = block_count_i, go to ARM.
  - start_i in any other state is ignored.
- **ARM:**
  - dat_start_o = 1 and wr_ptr is cleared; go to FILL.
- **FILL:**
  - wr_valid_i writes mem[wr_ptr]. If wr_ptr < words, wr_ptr increments; otherwise the word is dropped and an overflow flag is set.
  - On blk_done_i, compute the effective count = wr_ptr + (the wr_valid_i accepted in the same cycle).
  - Error exit: if crc_err_i, end_bit_err_i, the overflow flag, or effective count ≠ words, pulse every applicable error (length_err_o for an overflow or count mismatch) and go to IDLE. The transfer ends with no transfer_complete_o.
  - Good exit: otherwise pulse buffer_read_ready_o, clear rd_ptr, go to DRAIN.
- **DRAIN:**
  - rd_data_o = mem[rd_ptr] combinationally (show-ahead); rd_en_i increments rd_ptr.
  - rd_en_i with rd_ptr = words-1: decrement blocks_left. If that was the last block, pulse transfer_complete_o and go to IDLE; otherwise go to ARM.
- rd_en_i outside DRAIN and wr_valid_i outside FILL are ignored.
- abort_i: in any state, go to IDLE next cycle and clear pointers and flags. No pulses are raised. abort_i wins over every event in the same cycle; reset wins over abort_i.
- Buffer contents are not cleared by reset, abort, or a new block. Stale data is never visible because rd_data_o is forced to 0 outside DRAIN.

## Timing
- **Reset:** state IDLE. All outputs are 0, including rd_data_o, busy_o and every pulse.
- All pulse outputs are registered, high for exactly one cycle.
- **Transfer start:** start_i in cycle N → dat_start_o and busy_o are high in N+1 (ARM); state is FILL in N+2.
- **Block end:** blk_done_i in cycle M → the status pulse is high in M+1 and DRAIN is entered in M+1. rd_en_i is honoured from M+1.
- **Last read:** final rd_en_i in cycle K → either dat_start_o is high in K+1, or transfer_complete_o is high in K+1 and busy_o is 0 in K+1.
- **Zero-count start:** start_i with block_count_i = 0 in cycle N → transfer_complete_o high in N+1.
- **Abort:** abort_i in cycle A → busy_o is 0 from A+1; dat_start_o is not asserted in A+1.
- No back-pressure to the deserializer is needed: a block is never started until the buffer is empty.

## Test plan
- **Single block:** block_size 512, count 1; 128 words 0x0000_0000..0x0000_007F, blk_done_i with the last word → buffer_read_ready_o one cycle later; 128 rd_en_i return the same values in order; transfer_complete_o follows the last read.
- **Partial word:** block_size 6, count 1; 2 words → words = 2, no length_err_o, rd_data_o returns both words, then 0 once back in IDLE.
- **Multi-block:** block_count 3, block_size 8 → exactly 3 dat_start_o pulses, each one cycle after the final read of the prior block; transfer_complete_o once after the third drain.
- **CRC error:** crc_err_i=1 with blk_done_i on block 1 of 2 → data_crc_err_o pulses; no buffer_read_ready_o, no second dat_start_o; busy_o low.
- **Length errors:** block_size 16 with only 3 words, then block_size 16 with 5 words → length_err_o pulses in both cases; rd_en_i is ignored afterwards.
- **Abort and reset mid-transfer:** abort_i mid-FILL with rd_en_i and wr_valid_i asserted → IDLE next cycle, no pulses. rst_i mid-DRAIN → all outputs 0 next cycle; a fresh start_i works normally.

Source files
------------

// File: rtl/dat_read_buffer.sv
// dat_read_buffer: one-block receive buffer between the DAT deserializer and
// the register interface. It captures words, checks the finished block for
// errors, and presents it as a show-ahead read port. For multi-block reads it
// restarts the deserializer only once the buffer has been fully drained.
module dat_read_buffer #(
  parameter int MaxBlockBitSize = 12,
  parameter int BlockCountWidth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic [BlockCountWidth-1:0] block_count_i,
  input  logic                       abort_i,
  output logic                       dat_start_o,
  input  logic                       wr_valid_i,
  input  logic [31:0]                wr_data_i,
  input  logic                       blk_done_i,
  input  logic                       crc_err_i,
  input  logic                       end_bit_err_i,
  input  logic                       rd_en_i,
  output logic [31:0]                rd_data_o,
  output logic                       buffer_read_ready_o,
  output logic                       transfer_complete_o,
  output logic                       data_crc_err_o,
  output logic                       data_end_bit_err_o,
  output logic                       length_err_o,
  output logic                       busy_o
);
  localparam int PW    = MaxBlockBitSize - 1;  // pointer / word-count width
  localparam int AW    = MaxBlockBitSize - 2;  // buffer address width
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, ARM, FILL, DRAIN} state_e;

  state_e                     state_q;
  logic [PW-1:0]              words_q, wr_ptr_q, rd_ptr_q;
  logic [BlockCountWidth-1:0] blocks_left_q;
  logic                       ovf_q;
  logic                       dat_start_q, rdy_q, done_q, crc_q, eb_q, len_q;
  logic [31:0]                mem [DEPTH];

  // Byte count rounded up to whole words; one extra bit holds the +3 carry.
  logic [MaxBlockBitSize:0] size_round;
  logic [PW-1:0]            words_d;
  logic                     in_fill, wr_in_range, wr_acc, ovf_now, len_bad;
  logic [PW-1:0]            eff_cnt;
  logic                     rd_last;

  // Block bookkeeping: accepted write, effective count and error summary.
  always_comb begin
    size_round  = {1'b0, block_size_i} + (MaxBlockBitSize+1)'(3);
    words_d     = size_round[MaxBlockBitSize:2];
    in_fill     = (state_q == FILL);
    wr_in_range = (wr_ptr_q < words_q);
    wr_acc      = in_fill && wr_valid_i && wr_in_range;
    eff_cnt     = wr_ptr_q + PW'(wr_acc);
    ovf_now     = ovf_q | (in_fill && wr_valid_i && !wr_in_range);
    len_bad     = ovf_now | (eff_cnt != words_q);
    rd_last     = (rd_ptr_q == words_q - PW'(1));
  end

  // Buffer storage; contents persist across reset and abort by design.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !abort_i) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Control FSM with registered one-cycle status pulses.
  always_ff @(posedge clk_i) begin
    dat_start_q <= 1'b0;
    rdy_q       <= 1'b0;
    done_q      <= 1'b0;
    crc_q       <= 1'b0;
    eb_q        <= 1'b0;
    len_q       <= 1'b0;
    if (rst_i) begin
      state_q       <= IDLE;
      words_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      blocks_left_q <= '0;
      ovf_q         <= 1'b0;
    end else if (abort_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (block_count_i == '0) begin
              done_q <= 1'b1;
            end else begin
              words_q       <= words_d;
              blocks_left_q <= block_count_i;
              dat_start_q   <= 1'b1;
              state_q       <= ARM;
            end
          end
        end
        ARM: begin
          wr_ptr_q <= '0;
          ovf_q    <= 1'b0;
          state_q  <= FILL;
        end
        FILL: begin
          if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
          if (in_fill && wr_valid_i && !wr_in_range) ovf_q <= 1'b1;
          if (blk_done_i) begin
            if (crc_err_i || end_bit_err_i || len_bad) begin
              crc_q   <= crc_err_i;
              eb_q    <= end_bit_err_i;
              len_q   <= len_bad;
              state_q <= IDLE;
            end else begin
              rdy_q    <= 1'b1;
              rd_ptr_q <= '0;
              state_q  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rd_en_i) begin
            if (rd_last) begin
              blocks_left_q <= blocks_left_q - BlockCountWidth'(1);
              if (blocks_left_q == BlockCountWidth'(1)) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                dat_start_q <= 1'b1;
                state_q     <= ARM;
              end
            end else begin
              rd_ptr_q <= rd_ptr_q + PW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Show-ahead read port, masked outside DRAIN so stale words never leak.
  always_comb begin
    rd_data_o = '0;
    if (state_q == DRAIN) rd_data_o = mem[rd_ptr_q[AW-1:0]];
  end

  assign dat_start_o         = dat_start_q;
  assign buffer_read_ready_o = rdy_q;
  assign transfer_complete_o = done_q;
  assign data_crc_err_o      = crc_q;
  assign data_end_bit_err_o  = eb_q;
  assign length_err_o        = len_q;
  assign busy_o              = (state_q != IDLE);
endmodule
